muldiv_seq: RTL and testbench

//  Multi-cycle, parametrised RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV M-extension unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle combinational multiplier.
module muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      muldiv_op_i,
   input  logic [XLEN-1:0] in1_i,
   input  logic [XLEN-1:0] in2_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] out_o
);

   localparam int unsigned CNT_W = $clog2(XLEN) + 1;
   localparam int unsigned W1    = XLEN + 1;
   localparam int unsigned W2    = 2 * XLEN;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic [W1-1:0]    a_q, a_d;
   logic [W2-1:0]    p_q, p_d;
   logic [XLEN-1:0]  out_d;

   // Operand sign handling at acceptance
   logic            sgn1, sgn2, s1, s2, div0, ovf;
   logic [XLEN-1:0] abs1;
   logic [W1-1:0]   abs2;

   always_comb begin
      sgn1 = !(muldiv_op_i == OP_MULHU || muldiv_op_i == OP_DIVU || muldiv_op_i == OP_REMU);
      sgn2 = (muldiv_op_i == OP_MUL || muldiv_op_i == OP_MULH ||
              muldiv_op_i == OP_DIV || muldiv_op_i == OP_REM);
      s1   = sgn1 & in1_i[XLEN-1];
      s2   = sgn2 & in2_i[XLEN-1];
      abs1 = s1 ? (~in1_i + XLEN'(1)) : in1_i;
      abs2 = s2 ? (~{in2_i[XLEN-1], in2_i} + W1'(1)) : {1'b0, in2_i};
      div0 = (in2_i == '0);
      ovf  = (muldiv_op_i == OP_DIV || muldiv_op_i == OP_REM) &&
             (in1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&in2_i);
   end

   // One multiply iteration: conditional add into the high half, then shift right
   logic [W1-1:0] mul_sum;
   logic [W2-1:0] mul_next;
   assign mul_sum  = {1'b0, p_q[W2-1:XLEN]} + (p_q[0] ? a_q : W1'(0));
   assign mul_next = {mul_sum, p_q[XLEN-1:1]};

   // One restoring-divide iteration over {rem, quot}
   logic [W1-1:0]   rem_sh;
   logic [W1:0]     div_diff;
   logic [W2-1:0]   div_next;
   assign rem_sh   = p_q[W2-1:XLEN-1];
   assign div_diff = {1'b0, rem_sh} - {1'b0, a_q};
   assign div_next = div_diff[W1] ? {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};

   logic [W2-1:0]   prod_fix;
   logic [XLEN-1:0] quot_fix, rem_fix;
   assign prod_fix = neg_q_q ? (~p_q + W2'(1)) : p_q;
   assign quot_fix = neg_q_q ? (~p_q[XLEN-1:0] + XLEN'(1)) : p_q[XLEN-1:0];
   assign rem_fix  = neg_r_q ? (~p_q[W2-1:XLEN] + XLEN'(1)) : p_q[W2-1:XLEN];

   // Next-state and datapath next values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      a_d     = a_q;
      p_d     = p_q;
      out_d   = out_o;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  op_d    = muldiv_op_i;
                  neg_q_d = s1 ^ s2;
                  neg_r_d = s1;
                  a_d     = abs2;
                  p_d     = {XLEN'(0), abs1};
                  cnt_d   = CNT_W'(XLEN);
                  if (muldiv_op_i[2] && div0) begin
                     out_d   = muldiv_op_i[1] ? in1_i : '1;
                     state_d = DONE;
                  end else if (ovf) begin
                     out_d   = muldiv_op_i[1] ? XLEN'(0) : in1_i;
                     state_d = DONE;
                  end else if (!muldiv_op_i[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                     p_d     = W2'(abs1) * W2'(abs2[XLEN-1:0]);
                     state_d = FIXUP;
`else
                     state_d = CALC;
`endif
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               p_d   = op_q[2] ? div_next : mul_next;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = FIXUP;
            end
            FIXUP: begin
               case (op_q)
                  OP_MUL:                      out_d = prod_fix[XLEN-1:0];
                  OP_MULH, OP_MULHSU, OP_MULHU: out_d = prod_fix[W2-1:XLEN];
                  OP_DIV, OP_DIVU:             out_d = quot_fix;
                  default:                     out_d = rem_fix;
               endcase
               state_d = DONE;
            end
            DONE: begin
               if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_o <= (state_d == IDLE);
         rsp_valid_o <= (state_d == DONE);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         op_q    <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         a_q     <= '0;
         p_q     <= '0;
         out_o   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         a_q     <= a_d;
         p_q     <= p_d;
         out_o   <= out_d;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (XLEN=32).
module tb_muldiv_seq;

   localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            flush = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [2:0]      op = 3'd0;
   logic [XLEN-1:0] in1 = '0;
   logic [XLEN-1:0] in2 = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [XLEN-1:0] out;

   int n_vec = 0;
   int n_err = 0;

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .muldiv_op_i (op),
      .in1_i       (in1),
      .in2_i       (in2),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .out_o       (out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accept edge
   task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int w = 0;
      while (!req_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      check_eq("req_ready_wait", 32'(req_ready), 32'd1);
      op = o; in1 = a; in2 = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      in1 = 32'hDEAD_BEEF; in2 = 32'h0BAD_F00D; op = 3'd7;
   endtask

   task automatic wait_rsp(output logic [31:0] res, output int lat);
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out;
   endtask

   task automatic run_vec(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int          lat;
      start_op(o, a, b);
      wait_rsp(res, lat);
      check_eq(tag, res, exp);
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      int          seen;

      #12;
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_out", out, 32'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      run_vec("mul_m1m1",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);
      run_vec("mulh_m1m1",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
      run_vec("mulhu_m1m1",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
      run_vec("mulhsu_m1m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
      run_vec("mul_small",   OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT);
      run_vec("mulh_min",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
      run_vec("mulhu_min",   OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
      run_vec("mulhsu_neg",  OP_MULHSU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, MUL_LAT);
      run_vec("mulhsu_pos",  OP_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);

      run_vec("div_m7_2",    OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
      run_vec("rem_m7_2",    OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
      run_vec("divu_100_7",  OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT);
      run_vec("remu_100_7",  OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
      run_vec("div_7_m2",    OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
      run_vec("rem_7_m2",    OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT);
      run_vec("div_min_2",   OP_DIV,    32'h80000000, 32'd2,        32'hC0000000, DIV_LAT);
      run_vec("divu_max_1",  OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT);
      run_vec("remu_max_16", OP_REMU,   32'hFFFFFFFF, 32'h10,       32'h0000000F, DIV_LAT);

      run_vec("div_by0",     OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_vec("divu_by0",    OP_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
      run_vec("remu_by0",    OP_REMU,   32'd5,        32'd0,        32'd5,        1);
      run_vec("rem_by0",     OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
      run_vec("div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_vec("rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

      // Back-pressure in DONE
      rsp_ready = 1'b0;
      start_op(OP_DIVU, 32'd100, 32'd7);
      wait_rsp(res, lat);
      check_eq("bp_first", res, 32'd14);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("bp_valid", 32'(rsp_valid), 32'd1);
         check_eq("bp_out", out, 32'd14);
         check_eq("bp_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_release_valid", 32'(rsp_valid), 32'd0);
      check_eq("bp_release_ready", 32'(req_ready), 32'd1);
      check_eq("bp_out_hold", out, 32'd14);

      // Flush mid-CALC, with a competing early-out request that must be ignored
      start_op(OP_DIV, 32'd1000, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      req_valid = 1'b1; op = OP_DIV; in1 = 32'd5; in2 = 32'd0;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      check_eq("flush_valid", 32'(rsp_valid), 32'd0);
      check_eq("flush_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check_eq("flush_valid2", 32'(rsp_valid), 32'd0);
      run_vec("post_flush_div", OP_DIV, 32'd1000, 32'd3, 32'd333, DIV_LAT);

      // Asynchronous reset mid-CALC
      start_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (5) begin @(posedge clk); #1; end
      #2 reset = 1'b1;
      #1;
      check_eq("arst_req_ready", 32'(req_ready), 32'd1);
      check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("arst_out", out, 32'd0);
      @(negedge clk) reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1;
      end
      check_eq("arst_no_rsp", 32'(seen), 32'd0);
      run_vec("post_rst_remu", OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
